// File: rtl/bram_burst_adapter.sv
// Valid/ready burst front end for one BRAM port; absorbs the 1-cycle read latency via a 2-entry response FIFO.
// Define BRAM_ADAPTER_STATS_EN to add 32-bit read/write beat counters.
module bram_burst_adapter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [LEN_WIDTH-1:0]      req_len,
   input  logic [DATA_WIDTH/8-1:0]   req_strobe,
   input  logic                      wdata_valid,
   output logic                      wdata_ready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_WIDTH-1:0]     resp_data,
   output logic                      resp_last,
   output logic                      bram_en,
   output logic [DATA_WIDTH/8-1:0]   bram_write_en,
   output logic [ADDR_WIDTH-1:0]     bram_addr,
   output logic [DATA_WIDTH-1:0]     bram_data_in,
`ifdef BRAM_ADAPTER_STATS_EN
   output logic [31:0]               stat_read_beats,
   output logic [31:0]               stat_write_beats,
`endif
   input  logic [DATA_WIDTH-1:0]     bram_data_out
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_WRESP} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [LEN_WIDTH-1:0]      r_len;
   logic [DATA_WIDTH/8-1:0]   r_strobe;
   logic [LEN_WIDTH:0]        r_beat;
   logic                      r_inflight;
   logic                      r_inflight_last;
   logic [DATA_WIDTH-1:0]     r_fifo_data [2];
   logic [1:0]                r_fifo_last;
   logic                      r_wr_ptr;
   logic                      r_rd_ptr;
   logic [1:0]                r_count;

   logic                      w_pop;
   logic                      w_issue_rd;
   logic                      w_wbeat;
   logic                      w_issue_last;
   logic                      w_beats_left;
   logic [2:0]                w_occupancy;

   assign w_beats_left = (r_beat <= {1'b0, r_len});
   assign w_issue_last = (r_beat == {1'b0, r_len});
   assign w_pop        = (r_state == S_READ) && (r_count != 2'd0) && resp_ready;
   // A pop in this cycle frees a slot, so issue may resume in the same cycle.
   assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue_rd   = (r_state == S_READ) && w_beats_left && (w_occupancy < 3'd2);
   assign w_wbeat      = (r_state == S_WRITE) && wdata_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      req_ready     = 1'b0;
      wdata_ready   = 1'b0;
      resp_valid    = 1'b0;
      resp_data     = '0;
      resp_last     = 1'b0;
      bram_en       = 1'b0;
      bram_write_en = '0;
      bram_addr     = '0;
      bram_data_in  = '0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = req_write ? S_WRITE : S_READ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            if (r_count != 2'd0) begin
               resp_valid = 1'b1;
               resp_data  = r_fifo_data[r_rd_ptr];
               resp_last  = r_fifo_last[r_rd_ptr];
            end else begin
               resp_valid = 1'b0;
            end
            if (w_issue_rd) begin
               bram_en   = 1'b1;
               bram_addr = r_addr;
            end else begin
               bram_en   = 1'b0;
            end
            if (w_pop && r_fifo_last[r_rd_ptr]) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_WRITE: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               bram_en       = 1'b1;
               bram_write_en = r_strobe;
               bram_addr     = r_addr;
               bram_data_in  = wdata;
               w_state_nxt   = w_issue_last ? S_WRESP : S_WRITE;
            end else begin
               w_state_nxt   = S_WRITE;
            end
         end
         S_WRESP: begin
            resp_valid = 1'b1;
            resp_last  = 1'b1;
            if (resp_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WRESP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr   <= '0;
         r_len    <= '0;
         r_strobe <= '0;
         r_beat   <= '0;
      end else if ((r_state == S_IDLE) && req_valid) begin
         r_addr   <= req_addr;
         r_len    <= req_len;
         r_strobe <= req_strobe;
         r_beat   <= '0;
      end else if (w_issue_rd || w_wbeat) begin
         r_addr   <= r_addr + ADDR_WIDTH'(1);
         r_beat   <= r_beat + (LEN_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_fifo_data[0]  <= '0;
         r_fifo_data[1]  <= '0;
         r_fifo_last     <= 2'b00;
         r_wr_ptr        <= 1'b0;
         r_rd_ptr        <= 1'b0;
         r_count         <= 2'd0;
      end else begin
         r_inflight      <= w_issue_rd;
         r_inflight_last <= w_issue_rd && w_issue_last;
         if (r_inflight) begin
            r_fifo_data[r_wr_ptr] <= bram_data_out;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef BRAM_ADAPTER_STATS_EN
   logic [31:0] r_stat_rd;
   logic [31:0] r_stat_wr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_rd <= 32'd0;
         r_stat_wr <= 32'd0;
      end else begin
         if (w_pop) begin
            r_stat_rd <= r_stat_rd + 32'd1;
         end
         if (w_wbeat) begin
            r_stat_wr <= r_stat_wr + 32'd1;
         end
      end
   end

   assign stat_read_beats  = r_stat_rd;
   assign stat_write_beats = r_stat_wr;
`endif

endmodule

// File: tb/tb_bram_burst_adapter.sv
// Bench for bram_burst_adapter: behavioural BRAM, word-level memory model, directed plan steps plus random bursts.
module tb_bram_burst_adapter;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int LW = 4;
   localparam int SW = DW/8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic [SW-1:0] req_strobe;
   logic          wdata_valid, wdata_ready;
   logic [DW-1:0] wdata;
   logic          resp_valid, resp_ready, resp_last;
   logic [DW-1:0] resp_data;
   logic          bram_en;
   logic [SW-1:0] bram_write_en;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_data_in, bram_data_out;
`ifdef BRAM_ADAPTER_STATS_EN
   logic [31:0]   stat_read_beats, stat_write_beats;
`endif

   logic [DW-1:0] bram_mem [0:1023];
   logic [DW-1:0] ref_mem  [0:1023];
   logic          mem_init;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   bram_burst_adapter dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_strobe(req_strobe),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
      .bram_en(bram_en), .bram_write_en(bram_write_en), .bram_addr(bram_addr),
      .bram_data_in(bram_data_in),
`ifdef BRAM_ADAPTER_STATS_EN
      .stat_read_beats(stat_read_beats), .stat_write_beats(stat_write_beats),
`endif
      .bram_data_out(bram_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Behavioural BRAM port: registered read, byte-enabled write.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) bram_mem[i] <= init_word(i);
      end else if (bram_en) begin
         for (int b = 0; b < SW; b++)
            if (bram_write_en[b]) bram_mem[bram_addr][8*b +: 8] <= bram_data_in[8*b +: 8];
         bram_data_out <= bram_mem[bram_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_ctl"}, 64'({wdata_ready, resp_valid, resp_last, bram_en, bram_write_en, bram_addr}), 64'd0);
      check({tag, "_data"}, 64'({resp_data, bram_data_in}), 64'd0);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accept edge with that edge's cycle count.
   task automatic accept_req(input logic w, input logic [AW-1:0] a, input int len,
                             input logic [SW-1:0] s, output int e);
      int n;
      n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = LW'(len); req_strobe = s;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_accept", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      e = cyc;
      req_valid = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input int len, input logic [SW-1:0] s,
                           input bit gaps, input logic [DW-1:0] d [16]);
      int e, beat, k, n;
      bit nogap;
      logic [AW-1:0] wa;
      accept_req(1'b1, a, len, s, e);
      beat = 0; k = 0; nogap = 1'b1;
      while (beat <= len && k < 200) begin
         wdata_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (!wdata_valid) nogap = 1'b0;
         wdata = d[beat];
         @(negedge clk);
         check("wr_ready", 64'(wdata_ready), 64'd1);
         if (wdata_valid) begin
            wa = a + AW'(beat);
            check("wr_port", 64'({bram_en, bram_write_en, bram_addr, bram_data_in}),
                  64'({1'b1, s, wa, d[beat]}));
            for (int b = 0; b < SW; b++)
               if (s[b]) ref_mem[wa][8*b +: 8] = d[beat][8*b +: 8];
            beat++;
         end else begin
            check("wr_gap_port", 64'({bram_en, bram_write_en}), 64'd0);
         end
         @(posedge clk); #1;
         k++;
      end
      wdata_valid = 1'b0;
      check("wr_beats_in_budget", 64'(k < 200), 64'd1);
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wr_ack_valid", 64'(resp_valid), 64'd1);
      if (nogap) check("wr_ack_latency", 64'(cyc), 64'(e + 1 + len));
      check("wr_ack_fields", 64'({resp_last, resp_data, wdata_ready, bram_en}), 64'({1'b1, 32'h0, 1'b0, 1'b0}));
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      check("wr_ack_held", 64'(resp_valid), 64'd1);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("wr_back_to_idle", 64'({req_ready, resp_valid}), 64'b10);
      @(posedge clk); #1;
   endtask

   // mode 0: resp_ready held 1; 1: toggled every 2 cycles; 2: random.
   task automatic do_read(input logic [AW-1:0] a, input int len, input int mode,
                          output logic [DW-1:0] last_data);
      int e, issued, popped, k;
      logic [AW-1:0] ea;
      accept_req(1'b0, a, len, '0, e);
      issued = 0; popped = 0; k = 0;
      last_data = '0;
      while (popped <= len && k < 300) begin
         case (mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ((k / 2) % 2) == 1;
            default: resp_ready = $urandom_range(0, 1) == 1;
         endcase
         @(negedge clk);
         check("rd_outstanding_le2", 64'((issued - popped) <= 2), 64'd1);
         if (bram_en) begin
            ea = a + AW'(issued);
            check("rd_port", 64'({bram_write_en, bram_addr}), 64'({4'h0, ea}));
            issued++;
         end
         if (resp_valid && resp_ready) begin
            ea = a + AW'(popped);
            check("rd_data", 64'(resp_data), 64'(ref_mem[ea]));
            check("rd_last", 64'(resp_last), 64'(popped == len));
            if (mode == 0) check("rd_latency", 64'(cyc), 64'(e + 2 + popped));
            last_data = resp_data;
            popped++;
         end
         @(posedge clk); #1;
         k++;
      end
      resp_ready = 1'b0;
      check("rd_done_in_budget", 64'(k < 300), 64'd1);
      check("rd_issued", 64'(issued), 64'(len + 1));
      @(negedge clk);
      check("rd_back_to_idle", 64'({req_ready, bram_en, resp_valid}), 64'b100);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DW-1:0] wd [16];
      logic [DW-1:0] rlast;
      logic          rw;
      logic [AW-1:0] ra;
      int            rl;
      int            e;
      reset = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_strobe = '0;
      wdata_valid = 1'b0; wdata = '0; resp_ready = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < 16; i++) wd[i] = '0;
      repeat (2) @(posedge clk);
      #1 mem_init = 1'b0;
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_idle("post_reset");
      @(posedge clk); #1;

`ifdef BRAM_ADAPTER_STATS_EN
      for (int i = 0; i < 3; i++) wd[i] = 32'hC0DE0000 + 32'(i);
      do_write(10'h200, 2, 4'hF, 1'b0, wd);
      do_read(10'h200, 4, 0, rlast);
      check("stat_write_beats", 64'(stat_write_beats), 64'd3);
      check("stat_read_beats", 64'(stat_read_beats), 64'd5);
`endif

      wd[0] = 32'h12345678;
      do_write(10'h005, 0, 4'hF, 1'b0, wd);
      do_read(10'h005, 0, 0, rlast);
      check("plan_single_rd", 64'(rlast), 64'h12345678);

      wd[0] = 32'hAABBCCDD;
      do_write(10'h010, 0, 4'hF, 1'b0, wd);
      wd[0] = 32'h11223344;
      do_write(10'h010, 0, 4'h3, 1'b0, wd);
      do_read(10'h010, 0, 0, rlast);
      check("plan_strobe_rd", 64'(rlast), 64'hAABB3344);

      for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
      do_write(10'h3FE, 3, 4'hF, 1'b0, wd);
      do_read(10'h3FE, 3, 0, rlast);
      check("plan_wrap_last", 64'(rlast), 64'd4);
      do_read(10'h3FE, 3, 1, rlast);

      do_read(10'h020, 7, 1, rlast);
      do_read(10'h020, 7, 0, rlast);

      wd[0] = 32'h00000000;
      do_write(10'h030, 0, 4'h0, 1'b0, wd);
      do_read(10'h030, 0, 0, rlast);

      for (int t = 0; t < 24; t++) begin
         rw = $urandom_range(0, 1) == 1;
         ra = AW'($urandom_range(0, 1023));
         rl = $urandom_range(0, 15);
         if (rw) begin
            for (int i = 0; i < 16; i++) wd[i] = $urandom;
            do_write(ra, rl, SW'($urandom_range(0, 15)), 1'b1, wd);
         end else begin
            do_read(ra, rl, (t % 3 == 0) ? 0 : 2, rlast);
         end
      end

      for (int i = 0; i < 16; i++) wd[i] = $urandom;
      accept_req(1'b1, 10'h100, 7, 4'hF, e);
      for (int b = 0; b < 2; b++) begin
         wdata_valid = 1'b1; wdata = wd[b];
         @(negedge clk);
         check("rst_wr_port", 64'({bram_en, bram_addr}), 64'({1'b1, 10'h100 + 10'(b)}));
         ref_mem[10'h100 + 10'(b)] = wd[b];
         @(posedge clk); #1;
      end
      wdata_valid = 1'b1; wdata = wd[2]; reset = 1'b1;
      @(negedge clk);
      check_idle("mid_reset");
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_reset_no_en", 64'(bram_en), 64'd0);
      @(posedge clk); #1 reset = 1'b0; wdata_valid = 1'b0;
      @(negedge clk);
      check_idle("after_reset");
      @(posedge clk); #1;
      do_read(10'h100, 7, 2, rlast);
      do_read(10'h0FF, 2, 0, rlast);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_burst_adapter.md
# bram_burst_adapter

Request/response front end for one port of the dual-port BRAM. Accepts single or burst read/write requests on a valid/ready handshake and drives the BRAM port (en, byte write-enable, address, write data), absorbing its 1-cycle read latency. Returns read data through a 2-entry response FIFO, so downstream back-pressure never loses a beat. Sits between a cache/bus master and the BRAM port it owns.

## Interface
Parameters:
- DATA_WIDTH, 32, BRAM word width; multiple of 8
- ADDR_WIDTH, 10, BRAM word-address width
- LEN_WIDTH, 4, burst length field width; beats = req_len + 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  adapter idle; request accepted on req_valid && req_ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  first word address
- req_len  in  LEN_WIDTH  beats minus one
- req_strobe  in  DATA_WIDTH/8  byte enables; applied to every write beat, ignored on reads
- wdata_valid  in  1  write beat present
- wdata_ready  out  1  write beat accepted on wdata_valid && wdata_ready
- wdata  in  DATA_WIDTH  write beat data
- resp_valid  out  1  response beat present
- resp_ready  in  1  response beat consumed
- resp_data  out  DATA_WIDTH  read data; 0 for the write acknowledge
- resp_last  out  1  final beat of a read burst, or the write acknowledge
- bram_en  out  1  to BRAM en
- bram_write_en  out  DATA_WIDTH/8  to BRAM write_en
- bram_addr  out  ADDR_WIDTH  to BRAM addr
- bram_data_in  out  DATA_WIDTH  to BRAM data_in
- bram_data_out  in  DATA_WIDTH  from BRAM data_out; valid the cycle after bram_en

## Operation
- FSM states: IDLE, READ, WRITE, WRESP.
- IDLE: req_ready=1. On handshake, latch addr, len, strobe and write. Go to WRITE if write, else READ.
- READ: issue counter, beat counter, 1-bit in-flight flag, 2-entry FIFO.
  - Issue a read (bram_en=1, bram_write_en=0, bram_addr=cur) when beats remain to issue and (fifo_count + inflight − pop_this_cycle) < 2.
  - The in-flight read pushes bram_data_out into the FIFO on the following edge.
  - resp_last is set on the entry holding beat len.
  - Go to IDLE on the pop of the last beat.
- WRITE: wdata_ready=1.
  - On each beat handshake, the same cycle drives bram_en=1, bram_write_en=strobe, bram_addr=cur and bram_data_in=wdata.
  - After beat len, go to WRESP. strobe=0 still consumes beats; the access is a harmless read.
- WRESP: resp_valid=1, resp_last=1, resp_data=0. Go to IDLE on resp_ready.
- Address increments by 1 per issued beat and wraps modulo 2^ADDR_WIDTH (0x3FF → 0x000 at default).
- bram_en=0 whenever no access is issued. bram_write_en=0 outside WRITE.
- The adapter owns one BRAM port only. Same-address collisions with the other port are that user's responsibility; the BRAM returns 0xDEADBEEF in that case.
- wdata_valid outside WRITE is ignored; wdata_ready=0.

## Timing
- Reset values: req_ready=1, all other outputs 0. FSM=IDLE, FIFO empty, in-flight cleared.
- Reset mid-burst aborts immediately:
  - no further bram_en;
  - FIFO contents are discarded;
  - words already written remain in the BRAM.
- Read, request accepted in cycle T:
  - first bram_en in T+1;
  - first resp_valid in T+3;
  - with resp_ready held at 1, one beat per cycle, last beat in T+3+len.
- Read back-pressure: with resp_ready=0, at most 2 beats are buffered and issue stalls. Issue resumes in the cycle a pop occurs.
- Write, request accepted in T:
  - wdata_ready from T+1;
  - with wdata_valid held at 1, one BRAM write per cycle;
  - acknowledge resp_valid in T+2+len.
- Back-to-back: req_ready returns to 1 in the cycle after the final response handshake.

## Configuration
- BRAM_ADAPTER_STATS_EN defined: adds outputs stat_read_beats and stat_write_beats, each 32 bits.
  - stat_read_beats increments on each read beat popped; stat_write_beats increments on each write beat accepted.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Single write then read: write addr 0x005, len 0, strobe 0xF, data 0x12345678 → ack with resp_last=1 and resp_data=0. Read addr 0x005 → resp_data 0x12345678, resp_last=1, first resp_valid 3 cycles after acceptance.
- Byte strobe: preload 0xAABBCCDD at 0x010, write 0x11223344 with strobe 0x3 → read returns 0xAABB3344.
- Burst with wrap: write 4 beats at 0x3FE with data 1..4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 hold 1..4. A 4-beat read returns 1,2,3,4 with resp_last only on 4.
- Back-pressure: 8-beat read with resp_ready toggled 0/1 every 2 cycles → all 8 beats in order, no loss or duplication, never more than 2 outstanding. With resp_ready=1, beats are contiguous.
- Reset mid-burst: assert reset during beat 2 of an 8-beat write → all outputs at reset values that cycle, bram_en stays 0. Beats 0–1 persist; addresses for beats 2–7 are unchanged.
- With BRAM_ADAPTER_STATS_EN defined: 3-beat write followed by 5-beat read → stat_write_beats=3, stat_read_beats=5.
